// File: rtl/polar_pkg.sv
// Shared polar-decoder definitions: f/g op encoding, scheduler states, LLR saturation.
// Pure declarations; no timing, no flow control.
package polar_pkg;

    localparam logic OP_F = 1'b0;
    localparam logic OP_G = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Largest magnitude representable in a sign-magnitude word of the given width.
    function automatic int sm_sat_mag(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    localparam int LLR_SAT_MAG = sm_sat_mag(8);

endpackage

// File: rtl/llr_fg_pe.sv
// Combinational min-sum f / partial-sum g processing element on sign-magnitude LLRs.
// Zero latency, no flow control; the caller registers the result.
module llr_fg_pe
    import polar_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  op,
    input  logic                  u,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int MW = DATA_WIDTH - 1;
    localparam int XW = DATA_WIDTH + 2;
    localparam logic [XW-1:0] SAT = XW'(sm_sat_mag(DATA_WIDTH));

    logic [MW-1:0]        w_mag_a;
    logic [MW-1:0]        w_mag_b;
    logic [MW-1:0]        w_min;
    logic                 w_f_sign;
    logic signed [XW-1:0] w_val_a;
    logic signed [XW-1:0] w_val_b;
    logic signed [XW-1:0] w_sum;
    logic [XW-1:0]        w_abs;
    logic [MW-1:0]        w_g_mag;

    always_comb begin
        w_mag_a  = a[MW-1:0];
        w_mag_b  = b[MW-1:0];
        w_min    = (w_mag_a < w_mag_b) ? w_mag_a : w_mag_b;
        // A zero magnitude must never carry a negative sign.
        w_f_sign = (w_min != '0) & (a[MW] ^ b[MW]);

        w_val_a  = a[MW] ? -$signed({3'b000, w_mag_a}) : $signed({3'b000, w_mag_a});
        w_val_b  = b[MW] ? -$signed({3'b000, w_mag_b}) : $signed({3'b000, w_mag_b});
        w_sum    = u ? (w_val_b - w_val_a) : (w_val_b + w_val_a);
        w_abs    = w_sum[XW-1] ? -w_sum : w_sum;
        w_g_mag  = (w_abs > SAT) ? SAT[MW-1:0] : w_abs[MW-1:0];

        result = '0;
        if (op == OP_G) begin
            result = {w_sum[XW-1] & (w_g_mag != '0), w_g_mag};
        end else begin
            result = {w_f_sign, w_min};
        end
    end

endmodule

// File: rtl/llr_stage_sched.sv
// Runs one f/g stage over 2^(s-1) LLR pairs: one read pair per cycle, write 2 cycles after its read.
// No backpressure: memory is assumed always ready; start is ignored while busy.
module llr_stage_sched
    import polar_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N_LOG2     = 4,
    parameter int ADDR_W     = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          op,
    input  logic [$clog2(N_LOG2+1)-1:0]   stage,
    input  logic [ADDR_W-1:0]             rd_base,
    input  logic [ADDR_W-1:0]             wr_base,
    input  logic [2**(N_LOG2-1)-1:0]      psum,
    output logic                          rd_en,
    output logic [ADDR_W-1:0]             rd_addr_a,
    output logic [ADDR_W-1:0]             rd_addr_b,
    input  logic [DATA_WIDTH-1:0]         rd_data_a,
    input  logic [DATA_WIDTH-1:0]         rd_data_b,
    output logic                          wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int SW     = $clog2(N_LOG2 + 1);
    localparam int PSUM_W = 2 ** (N_LOG2 - 1);
    localparam int CW     = N_LOG2;

    sched_state_t          r_state;
    logic                  r_op;
    logic [ADDR_W-1:0]     r_wr_base;
    logic [PSUM_W-1:0]     r_psum;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         r_last;
    logic                  r_rd_en;
    logic [ADDR_W-1:0]     r_rd_addr_a;
    logic [ADDR_W-1:0]     r_rd_addr_b;
    logic                  r_d1_vld;
    logic [CW-1:0]         r_d1_idx;
    logic                  r_wr_en;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_legal;
    logic [CW-1:0]         w_pairs;
    logic [PSUM_W-1:0]     w_psum_sh;
    logic                  w_u;
    logic [DATA_WIDTH-1:0] w_pe_result;

    assign w_legal   = (stage != '0) && (stage <= SW'(N_LOG2));
    assign w_pairs   = CW'(1) << (stage - SW'(1));
    assign w_psum_sh = r_psum >> r_d1_idx;
    assign w_u       = w_psum_sh[0];

    llr_fg_pe #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pe (
        .a      (rd_data_a),
        .b      (rd_data_b),
        .op     (r_op),
        .u      (w_u),
        .result (w_pe_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= 1'b0;
            r_wr_base   <= '0;
            r_psum      <= '0;
            r_cnt       <= '0;
            r_last      <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_d1_vld    <= 1'b0;
            r_d1_idx    <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Pipeline: read issued -> data returns (d1) -> PE result registered as a write.
            r_d1_vld <= r_rd_en;
            r_d1_idx <= r_cnt;
            r_done   <= 1'b0;
            r_err    <= 1'b0;

            if (r_d1_vld) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_wr_base + ADDR_W'(r_d1_idx);
                r_wr_data <= w_pe_result;
            end else begin
                r_wr_en   <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op      <= op;
                        r_wr_base <= wr_base;
                        r_psum    <= psum;
                        r_busy    <= 1'b1;
                        if (w_legal) begin
                            r_state     <= RUN;
                            r_rd_en     <= 1'b1;
                            r_rd_addr_a <= rd_base;
                            r_rd_addr_b <= rd_base + ADDR_W'(w_pairs);
                            r_cnt       <= '0;
                            r_last      <= w_pairs - CW'(1);
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (r_cnt == r_last) begin
                        r_rd_en <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_cnt       <= r_cnt + CW'(1);
                        r_rd_addr_a <= r_rd_addr_a + ADDR_W'(1);
                        r_rd_addr_b <= r_rd_addr_b + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // Last write is on the bus and nothing is left behind it.
                    if (r_wr_en && !r_d1_vld) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_en     = r_rd_en;
    assign rd_addr_a = r_rd_addr_a;
    assign rd_addr_b = r_rd_addr_b;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_llr_stage_sched.sv
// Directed bench for llr_stage_sched: synchronous memory model, read/write scoreboards, timing checks.
module tb_llr_stage_sched;
    import polar_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [2:0] stage = '0;
    logic [5:0] rd_base = '0;
    logic [5:0] wr_base = '0;
    logic [7:0] psum = '0;
    logic       rd_en;
    logic [5:0] rd_addr_a;
    logic [5:0] rd_addr_b;
    logic [7:0] rd_data_a = '0;
    logic [7:0] rd_data_b = '0;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       err;

    llr_stage_sched #(.DATA_WIDTH(8), .N_LOG2(4), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .stage(stage),
        .rd_base(rd_base), .wr_base(wr_base), .psum(psum),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
        end
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] f_model(input logic [7:0] a, input logic [7:0] b);
        logic [6:0] m;
        m = (a[6:0] < b[6:0]) ? a[6:0] : b[6:0];
        return {(m != 7'd0) & (a[7] ^ b[7]), m};
    endfunction

    function automatic logic [7:0] g_model(input logic [7:0] a, input logic [7:0] b, input logic u);
        int va, vb, r;
        va = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
        vb = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
        r  = u ? (vb - va) : (vb + va);
        if (r > 127)  r = 127;
        if (r < -127) r = -127;
        return (r < 0) ? {1'b1, 7'(-r)} : {1'b0, 7'(r)};
    endfunction

    logic [11:0] exp_rd_q[$];
    logic [13:0] exp_wr_q[$];
    int          rd_cyc_q[$];
    int rd_cnt = 0, wr_total = 0, busy_cnt = 0, done_seen = 0;
    int done_cyc = 0, last_wr_cyc = 0, start_cyc = 0, exp_pairs = 0, done_target = 0;
    logic done_err = 1'b0;
    logic [11:0] mon_rd_e;
    logic [13:0] mon_wr_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (rd_en) begin
                rd_cnt++;
                rd_cyc_q.push_back(cyc);
                check("rd_expected", exp_rd_q.size() > 0, 1);
                if (exp_rd_q.size() > 0) begin
                    mon_rd_e = exp_rd_q.pop_front();
                    check("rd_addr_a", rd_addr_a, mon_rd_e[11:6]);
                    check("rd_addr_b", rd_addr_b, mon_rd_e[5:0]);
                end
            end
            if (wr_en) begin
                wr_total++;
                last_wr_cyc = cyc;
                check("wr_expected", exp_wr_q.size() > 0, 1);
                if (exp_wr_q.size() > 0) begin
                    mon_wr_e = exp_wr_q.pop_front();
                    check("wr_addr", wr_addr, mon_wr_e[13:8]);
                    check("wr_data", wr_data, mon_wr_e[7:0]);
                end
                check("wr_has_rd", rd_cyc_q.size() > 0, 1);
                if (rd_cyc_q.size() > 0) check("wr_latency", cyc - rd_cyc_q.pop_front(), 2);
            end
            if (done) begin
                done_seen++;
                done_cyc = cyc;
                done_err = err;
            end
            if (err) check("err_with_done", done, 1);
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that accepted start.
    task automatic issue(input logic o, input logic [2:0] s, input logic [5:0] rb,
                         input logic [5:0] wb, input logic [7:0] ps);
        int p;
        logic [5:0] aa, ba;
        logic [7:0] res;
        p = 0;
        if (s >= 3'd1 && s <= 3'd4) begin
            p = 1 << (s - 1);
            for (int i = 0; i < p; i++) begin
                aa  = rb + 6'(i);
                ba  = rb + 6'(i + p);
                res = o ? g_model(mem[aa], mem[ba], ps[i]) : f_model(mem[aa], mem[ba]);
                exp_rd_q.push_back({aa, ba});
                exp_wr_q.push_back({wb + 6'(i), res});
            end
        end
        exp_pairs   = p;
        rd_cnt      = 0;
        busy_cnt    = 0;
        done_target = done_seen + 1;
        start_cyc   = cyc;
        op = o; stage = s; rd_base = rb; wr_base = wb; psum = ps; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; stage = 3'd0;
        rd_base = 6'($urandom); wr_base = 6'($urandom); psum = ~ps;
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        for (int k = 0; k < 100 && done_seen < done_target; k++) @(posedge clk);
        @(posedge clk); #1;
        check({tag, "_done_seen"}, done_seen >= done_target, 1);
        check({tag, "_err"}, done_err, exp_err);
        check({tag, "_done_cyc"}, done_cyc - start_cyc, exp_err ? 1 : exp_pairs + 3);
        check({tag, "_rd_count"}, rd_cnt, exp_pairs);
        check({tag, "_busy_cycles"}, busy_cnt, exp_err ? 1 : exp_pairs + 3);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_wr_pending"}, exp_wr_q.size(), 0);
        if (!exp_err) check({tag, "_done_after_wr"}, done_cyc - last_wr_cyc, 1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rd_addr_a"}, rd_addr_a, 0);
        check({tag, "_rd_addr_b"}, rd_addr_b, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int wr_before;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h05; mem[1] = 8'h83; mem[2] = 8'h82; mem[3] = 8'h07;
        mem[16] = 8'h64; mem[17] = 8'hBC;
        mem[24] = 8'h00; mem[25] = 8'h89;

        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // f, stage 2: {+5,-3,-2,+7} -> mem[8] = -2, mem[9] = -3
        issue(OP_F, 3'd2, 6'd0, 6'd8, 8'h00);
        wait_done("f_s2", 1'b0);
        check("f_s2_mem8", mem[8], 8'h82);
        check("f_s2_mem9", mem[9], 8'h83);

        // g, stage 1: a=+100, b=-60
        issue(OP_G, 3'd1, 6'd16, 6'd20, 8'h01);
        wait_done("g_sub", 1'b0);
        check("g_sub_sat", mem[20], 8'hFF);
        issue(OP_G, 3'd1, 6'd16, 6'd21, 8'h00);
        wait_done("g_add", 1'b0);
        check("g_add_val", mem[21], 8'h28);

        // f with +0 and -9: zero result keeps a positive sign
        issue(OP_F, 3'd1, 6'd24, 6'd26, 8'h00);
        wait_done("f_zero", 1'b0);
        check("f_zero_val", mem[26], 8'h00);

        // stage 4 from base 60 wraps; a second start mid-RUN must be ignored
        issue(OP_G, 3'd4, 6'd60, 6'd32, 8'hA5);
        repeat (2) @(posedge clk);
        #1;
        op = OP_F; stage = 3'd1; rd_base = 6'd40; wr_base = 6'd44; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("g_s4_wrap", 1'b0);

        // illegal stages
        wr_before = wr_total;
        issue(OP_F, 3'd0, 6'd0, 6'd48, 8'h00);
        wait_done("stage0", 1'b1);
        issue(OP_G, 3'd5, 6'd0, 6'd48, 8'h00);
        wait_done("stage5", 1'b1);
        check("illegal_no_write", wr_total - wr_before, 0);

        // reset after the third write of a stage-4 command
        wr_before = wr_total;
        issue(OP_F, 3'd4, 6'd0, 6'd40, 8'h00);
        for (int k = 0; k < 40 && wr_total < wr_before + 3; k++) begin
            @(negedge clk); #1;
        end
        check("rst_third_write", wr_total - wr_before, 3);
        rst_n = 1'b0;
        #1;
        check_quiet("midrst");
        exp_rd_q.delete();
        exp_wr_q.delete();
        rd_cyc_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_write", wr_total - wr_before, 3);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_quiet("post_rst");
        issue(OP_F, 3'd1, 6'd2, 6'd50, 8'h00);
        wait_done("after_rst", 1'b0);
        check("after_rst_val", mem[50], f_model(mem[2], mem[3]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
